pulse_pair_collector: RTL and testbench

- Sits directly upstream of the serial transmitter.
- Takes decoded LFSR hits (17-bit offset plus 17-bit polynomial) from the sensor decoder.
- Pairs two hits of the same polynomial, the two sweeps of one lighthouse rotation, into pulse_id_0 and pulse_id_1.
- Raises data_availible and holds the pair stable until the transmitter acknowledges with reset_pulse_identifier.

---
 rtl/pulse_pair_collector.sv | 135 +++++++++++++
 tb/tb_pulse_pair_collector.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_pair_collector.sv
// rtl/pulse_pair_collector.sv - pairs two same-polynomial LFSR hits for the serial transmitter
// Optional feature macro: PULSE_ID_DROP_COUNT_EN (adds the saturating dropped_count output).
module pulse_pair_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 120000,
  parameter int unsigned MIN_GAP        = 120
) (
  input  logic        clk_12MHz,
  input  logic        rstn,
  input  logic        decoded_valid,
  input  logic [16:0] decoded_offset,
  input  logic [16:0] decoded_polynomial,
  input  logic        reset_pulse_identifier,
  output logic [16:0] pulse_id_0,
  output logic [16:0] pulse_id_1,
  output logic [16:0] polynomial,
`ifdef PULSE_ID_DROP_COUNT_EN
  output logic [7:0]  dropped_count,
`endif
  output logic        data_availible
);

  typedef enum logic [1:0] {
    WAIT_FIRST  = 2'd0,
    WAIT_SECOND = 2'd1,
    READY       = 2'd2
  } state_t;

  localparam logic [16:0] MIN_GAP_C      = 17'(MIN_GAP);
  localparam logic [16:0] TIMEOUT_LAST_C = 17'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [16:0] counter_q, counter_d;
  logic [16:0] pulse_id_0_q, pulse_id_0_d;
  logic [16:0] pulse_id_1_q, pulse_id_1_d;
  logic [16:0] polynomial_q, polynomial_d;
  logic        data_availible_q, data_availible_d;
`ifdef PULSE_ID_DROP_COUNT_EN
  logic [7:0]  dropped_count_q, dropped_count_d;
`endif
  logic        drop_event;

  always_comb begin
    state_d          = state_q;
    counter_d        = counter_q;
    pulse_id_0_d     = pulse_id_0_q;
    pulse_id_1_d     = pulse_id_1_q;
    polynomial_d     = polynomial_q;
    data_availible_d = data_availible_q;
    drop_event       = 1'b0;

    case (state_q)
      WAIT_FIRST: begin
        if (decoded_valid) begin
          pulse_id_0_d = decoded_offset;
          polynomial_d = decoded_polynomial;
          counter_d    = 17'd0;
          state_d      = WAIT_SECOND;
        end
      end
      WAIT_SECOND: begin
        counter_d = counter_q + 17'd1;
        // A different polynomial restarts the pair even on the timeout cycle.
        if (decoded_valid && (decoded_polynomial != polynomial_q)) begin
          pulse_id_0_d = decoded_offset;
          polynomial_d = decoded_polynomial;
          counter_d    = 17'd0;
        end else if (decoded_valid && (counter_q >= MIN_GAP_C)) begin
          pulse_id_1_d     = decoded_offset;
          data_availible_d = 1'b1;
          counter_d        = 17'd0;
          state_d          = READY;
        end else if (counter_q == TIMEOUT_LAST_C) begin
          counter_d  = 17'd0;
          drop_event = 1'b1;
          state_d    = WAIT_FIRST;
        end
      end
      READY: begin
        drop_event = decoded_valid;
        if (reset_pulse_identifier) begin
          data_availible_d = 1'b0;
          state_d          = WAIT_FIRST;
        end
      end
      default: begin
        state_d = WAIT_FIRST;
      end
    endcase
  end

`ifdef PULSE_ID_DROP_COUNT_EN
  always_comb begin
    dropped_count_d = dropped_count_q;
    if (drop_event && (dropped_count_q != 8'hff)) begin
      dropped_count_d = dropped_count_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk_12MHz) begin
    if (!rstn) begin
      state_q          <= WAIT_FIRST;
      counter_q        <= 17'd0;
      pulse_id_0_q     <= 17'd0;
      pulse_id_1_q     <= 17'd0;
      polynomial_q     <= 17'd0;
      data_availible_q <= 1'b0;
`ifdef PULSE_ID_DROP_COUNT_EN
      dropped_count_q  <= 8'd0;
`endif
    end else begin
      state_q          <= state_d;
      counter_q        <= counter_d;
      pulse_id_0_q     <= pulse_id_0_d;
      pulse_id_1_q     <= pulse_id_1_d;
      polynomial_q     <= polynomial_d;
      data_availible_q <= data_availible_d;
`ifdef PULSE_ID_DROP_COUNT_EN
      dropped_count_q  <= dropped_count_d;
`endif
    end
  end

  assign pulse_id_0     = pulse_id_0_q;
  assign pulse_id_1     = pulse_id_1_q;
  assign polynomial     = polynomial_q;
  assign data_availible = data_availible_q;
`ifdef PULSE_ID_DROP_COUNT_EN
  assign dropped_count  = dropped_count_q;
`else
  logic unused_drop_event;
  assign unused_drop_event = drop_event;
`endif

endmodule

// File: tb/tb_pulse_pair_collector.sv
// tb/tb_pulse_pair_collector.sv - directed and randomized bench for pulse_pair_collector
module tb_pulse_pair_collector;

  localparam int TO = 400;
  localparam int MG = 120;

  logic        clk_12MHz = 1'b0;
  logic        rstn;
  logic        decoded_valid;
  logic [16:0] decoded_offset;
  logic [16:0] decoded_polynomial;
  logic        reset_pulse_identifier;
  logic [16:0] pulse_id_0;
  logic [16:0] pulse_id_1;
  logic [16:0] polynomial;
  logic        data_availible;
`ifdef PULSE_ID_DROP_COUNT_EN
  logic [7:0]  dropped_count;
`endif

  always #5 clk_12MHz = ~clk_12MHz;

  pulse_pair_collector #(.TIMEOUT_CYCLES(TO), .MIN_GAP(MG)) dut (
    .clk_12MHz              (clk_12MHz),
    .rstn                   (rstn),
    .decoded_valid          (decoded_valid),
    .decoded_offset         (decoded_offset),
    .decoded_polynomial     (decoded_polynomial),
    .reset_pulse_identifier (reset_pulse_identifier),
    .pulse_id_0             (pulse_id_0),
    .pulse_id_1             (pulse_id_1),
    .polynomial             (polynomial),
`ifdef PULSE_ID_DROP_COUNT_EN
    .dropped_count          (dropped_count),
`endif
    .data_availible         (data_availible)
  );

  int passes = 0;
  int checks = 0;
  int fails  = 0;

  // Reference: time-stamped first hit instead of a counter.
  int          cyc = 0;
  bit          m_ready, m_have;
  int          m_first;
  logic [16:0] m_id0, m_id1, m_poly;
  int          m_drop;

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    int el;
    cyc++;
    if (!rstn) begin
      m_ready = 0; m_have = 0; m_id0 = 0; m_id1 = 0; m_poly = 0; m_drop = 0;
    end else if (m_ready) begin
      if (decoded_valid && m_drop < 255) m_drop++;
      if (reset_pulse_identifier) m_ready = 0;
    end else if (m_have) begin
      el = cyc - m_first;
      if (decoded_valid && decoded_polynomial != m_poly) begin
        m_id0 = decoded_offset; m_poly = decoded_polynomial; m_first = cyc;
      end else if (decoded_valid && (el - 1) >= MG) begin
        m_id1 = decoded_offset; m_ready = 1; m_have = 0;
      end else if (el == TO) begin
        m_have = 0;
        if (m_drop < 255) m_drop++;
      end
    end else if (decoded_valid) begin
      m_id0 = decoded_offset; m_poly = decoded_polynomial; m_have = 1; m_first = cyc;
    end
  endtask

  task automatic tick(input logic iv, input logic [16:0] ioff, input logic [16:0] ipoly, input logic iack);
    decoded_valid          = iv;
    decoded_offset         = ioff;
    decoded_polynomial     = ipoly;
    reset_pulse_identifier = iack;
    @(posedge clk_12MHz);
    model_step();
    #1;
    chk("pulse_id_0", pulse_id_0, m_id0);
    chk("pulse_id_1", pulse_id_1, m_id1);
    chk("polynomial", polynomial, m_poly);
    chk("data_availible", {16'd0, data_availible}, {16'd0, m_ready});
`ifdef PULSE_ID_DROP_COUNT_EN
    chk("dropped_count", {9'd0, dropped_count}, 17'(m_drop));
`endif
    decoded_valid          = 1'b0;
    reset_pulse_identifier = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 17'd0, 17'd0, 1'b0);
  endtask

  task automatic hit(input logic [16:0] off, input logic [16:0] poly);
    tick(1'b1, off, poly, 1'b0);
  endtask

  task automatic ack();
    tick(1'b0, 17'd0, 17'd0, 1'b1);
  endtask

  initial begin
    int rate;
    rstn = 1'b0;
    decoded_valid = 1'b0; decoded_offset = '0; decoded_polynomial = '0; reset_pulse_identifier = 1'b0;
    idle(2);
    chk("reset_data", {16'd0, data_availible}, 17'd0);
    chk("reset_id0", pulse_id_0, 17'd0);
    rstn = 1'b1;

    // nominal pair
    hit(17'h00123, 17'h00005); idle(199); hit(17'h04567, 17'h00005);
    chk("nom_data", {16'd0, data_availible}, 17'd1);
    chk("nom_id0", pulse_id_0, 17'h00123);
    chk("nom_id1", pulse_id_1, 17'h04567);
    chk("nom_poly", polynomial, 17'h00005);
    idle(3); ack();
    chk("nom_ack_data", {16'd0, data_availible}, 17'd0);
    chk("nom_ack_id1", pulse_id_1, 17'h04567);

    // duplicate suppression: counter 50 ignored, counter 300 accepted
    hit(17'h00aaa, 17'h00005); idle(50); hit(17'h00bbb, 17'h00005); idle(249);
    chk("dup_pre_data", {16'd0, data_availible}, 17'd0);
    hit(17'h00999, 17'h00005);
    chk("dup_id0", pulse_id_0, 17'h00aaa);
    chk("dup_id1", pulse_id_1, 17'h00999);
    ack();

    // MIN_GAP boundary: counter MG-1 ignored, counter MG accepted
    hit(17'h00001, 17'h00009); idle(MG - 1); hit(17'h00002, 17'h00009);
    chk("gap_lo_data", {16'd0, data_availible}, 17'd0);
    hit(17'h00003, 17'h00009);
    chk("gap_hi_id1", pulse_id_1, 17'h00003);
    ack();

    // polynomial switch
    hit(17'h00010, 17'h00005); idle(9); hit(17'h00020, 17'h00007); idle(199); hit(17'h00030, 17'h00007);
    chk("sw_id0", pulse_id_0, 17'h00020);
    chk("sw_id1", pulse_id_1, 17'h00030);
    chk("sw_poly", polynomial, 17'h00007);
    ack();

    // timeout, then late hit becomes a new first hit
    hit(17'h00040, 17'h00005); idle(TO); hit(17'h00041, 17'h00005);
    chk("to_data", {16'd0, data_availible}, 17'd0);
    chk("to_id0", pulse_id_0, 17'h00041);
    idle(TO);
    // accept on the timeout cycle wins
    hit(17'h00050, 17'h00005); idle(TO - 1); hit(17'h00051, 17'h00005);
    chk("to_edge_data", {16'd0, data_availible}, 17'd1);

    // busy drop: three strobes in READY, one on the ack edge
    hit(17'h00060, 17'h00005); hit(17'h00061, 17'h00006);
    tick(1'b1, 17'h00062, 17'h00005, 1'b1);
    chk("busy_id0", pulse_id_0, 17'h00050);
    chk("busy_id1", pulse_id_1, 17'h00051);
    idle(5);
    chk("busy_idle_id0", pulse_id_0, 17'h00050);

    // reset in WAIT_SECOND and in READY
    hit(17'h00070, 17'h00003); idle(5);
    rstn = 1'b0; idle(1); rstn = 1'b1;
    chk("rst_ws_id0", pulse_id_0, 17'd0);
    hit(17'h00071, 17'h00003); idle(130); hit(17'h00072, 17'h00003);
    rstn = 1'b0; idle(1); rstn = 1'b1;
    chk("rst_rd_data", {16'd0, data_availible}, 17'd0);
    chk("rst_rd_id1", pulse_id_1, 17'd0);
    hit(17'h00073, 17'h00003); idle(130); hit(17'h00074, 17'h00003);
    chk("rst_after_id0", pulse_id_0, 17'h00073);

    // randomized traffic in blocks of varying strobe density
    for (int b = 0; b < 24; b++) begin
      rate = $urandom_range(1, 30);
      for (int i = 0; i < 1000; i++) begin
        rstn = ($urandom_range(0, 2999) != 0);
        tick($urandom_range(0, 999) < rate, 17'($urandom),
             ($urandom_range(0, 1) == 0) ? 17'h00005 : 17'h1abcd,
             $urandom_range(0, 15) == 0);
      end
    end
    rstn = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
